// File: rtl/down_timer.sv
// down_timer: loadable down-counter with one-shot or periodic reload and a registered tc pulse.
// Define DOWN_TIMER_PRESCALER_EN to add the prescale port and a PRE_W tick prescaler.
module down_timer #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned PRE_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   input  logic             start,
   input  logic             stop,
   input  logic             periodic,
   input  logic             enable,
`ifdef DOWN_TIMER_PRESCALER_EN
   input  logic [PRE_W-1:0] prescale,
`endif
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             busy
);

   typedef enum logic [0:0] {StIdle, StRun} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic [WIDTH-1:0] reload_q, reload_d;
   logic [WIDTH-1:0] eff_reload;
   logic             tc_q, tc_d;
   logic             tick;

   if (WIDTH < 1 || PRE_W < 1) begin : g_param_check
      $error("down_timer: WIDTH and PRE_W must be at least 1");
   end

`ifdef DOWN_TIMER_PRESCALER_EN
   logic [PRE_W-1:0] pre_q, pre_d;
   logic             pre_wrap;

   assign pre_wrap = (pre_q == prescale);
   assign tick     = enable & pre_wrap;

   // Held at zero outside RUN so every RUN entry starts a fresh prescale period.
   always_comb begin
      pre_d = pre_q;
      if (state_q != StRun || stop) begin
         pre_d = '0;
      end else if (enable) begin
         pre_d = pre_wrap ? '0 : pre_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pre_q <= '0;
      end else begin
         pre_q <= pre_d;
      end
   end
`else
   assign tick = enable;
`endif

   // A load in the same cycle as start supplies the reload value directly.
   assign eff_reload = load ? load_value : reload_q;

   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      reload_d = load ? load_value : reload_q;
      tc_d     = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (load) begin
               count_d = load_value;
            end
            if (start) begin
               if (eff_reload != '0) begin
                  state_d = StRun;
                  count_d = eff_reload;
               end else begin
                  tc_d    = 1'b1;
                  count_d = '0;
               end
            end
         end
         StRun: begin
            // stop takes priority over a terminal-count tick in the same cycle.
            if (stop) begin
               state_d = StIdle;
            end else if (tick) begin
               if (count_q != '0) begin
                  count_d = count_q - 1'b1;
               end else begin
                  tc_d = 1'b1;
                  if (periodic) begin
                     count_d = reload_q;
                  end else begin
                     state_d = StIdle;
                  end
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         count_q  <= '0;
         reload_q <= '0;
         tc_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         reload_q <= reload_d;
         tc_q     <= tc_d;
      end
   end

   assign count = count_q;
   assign tc    = tc_q;
   assign busy  = (state_q == StRun);

endmodule
